// File: rtl/reg_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_initiator_if
// Brief    : Command/response streams and shared register bus of the
//            byte-stream register initiator.
// Revision : 1.0
// ============================================================================
interface reg_bus_initiator_if #(
    parameter int pBYTECNT_SIZE = 7
) ();
    logic [7:0]               cmd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               rsp_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic                     busy;

    // Initiator side
    modport master (
        input  cmd_data, cmd_valid, rsp_ready, read_data,
        output cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, busy
    );

    // Host transport plus register responders
    modport slave (
        output cmd_data, cmd_valid, rsp_ready, read_data,
        input  cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_initiator
// Brief    : Decodes framed host commands into register-bus write/read bursts.
// Revision : 1.0
// ============================================================================
module reg_bus_initiator #(
    parameter int pBYTECNT_SIZE = 7
) (
    input  wire logic           cwusb_clk,
    input  wire logic           reset_n_i,
    reg_bus_initiator_if.master bus
);
    localparam int c_LEN_W = 7;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR       = 4'd1,
        S_WR_DATA   = 4'd2,
        S_WR_STROBE = 4'd3,
        S_RD_SETUP  = 4'd4,
        S_RD_CAP    = 4'd5,
        S_RD_HOLD   = 4'd6,
        S_DONE      = 4'd7
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_LEN_W-1:0]       r_len;
    logic [pBYTECNT_SIZE-1:0] r_k;
    logic [7:0]               r_address;
    logic [7:0]               r_write_data;
    logic [7:0]               r_rsp_data;
    logic                     r_cmd_ready;
    logic                     r_rsp_valid;
    logic                     r_reg_read;
    logic                     r_reg_write;
    logic                     r_addrvalid;
    logic                     r_busy;

    logic                     w_cmd_hs;
    logic                     w_rsp_hs;
    logic                     w_last;

    assign w_cmd_hs = bus.cmd_valid & r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;
    // Compared as k+1 == len so a zero length never underflows
    assign w_last   = ((32'(r_k) + 32'd1) == 32'(r_len));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_cmd_hs) begin
                    if (bus.cmd_data[c_LEN_W-1:0] == '0) w_state_nxt = S_DONE;
                    else if (bus.cmd_data[7])            w_state_nxt = S_RD_SETUP;
                    else                                 w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (w_cmd_hs) w_state_nxt = S_WR_STROBE;
            end
            S_WR_STROBE: begin
                w_state_nxt = w_last ? S_DONE : S_WR_DATA;
            end
            S_RD_SETUP: w_state_nxt = S_RD_CAP;
            S_RD_CAP:   w_state_nxt = S_RD_HOLD;
            S_RD_HOLD: begin
                if (w_rsp_hs) w_state_nxt = w_last ? S_DONE : S_RD_SETUP;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus flags are registered from the next state so they align with it
    always_ff @(posedge cwusb_clk) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_k          <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_rsp_data   <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_reg_read   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_addrvalid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_HDR) ||
                           (w_state_nxt == S_WR_DATA);
            r_reg_write <= (w_state_nxt == S_WR_STROBE);
            r_reg_read  <= (w_state_nxt == S_RD_SETUP) || (w_state_nxt == S_RD_CAP) ||
                           (w_state_nxt == S_RD_HOLD);
            r_rsp_valid <= (w_state_nxt == S_RD_HOLD);
            r_addrvalid <= (w_state_nxt == S_WR_DATA) || (w_state_nxt == S_WR_STROBE) ||
                           (w_state_nxt == S_RD_SETUP) || (w_state_nxt == S_RD_CAP) ||
                           (w_state_nxt == S_RD_HOLD);
            r_busy      <= (w_state_nxt != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) r_address <= bus.cmd_data;
                end
                S_HDR: begin
                    if (w_cmd_hs) begin
                        r_len <= bus.cmd_data[c_LEN_W-1:0];
                        r_k   <= '0;
                    end
                end
                S_WR_DATA: begin
                    if (w_cmd_hs) r_write_data <= bus.cmd_data;
                end
                S_WR_STROBE: begin
                    r_k <= w_last ? '0 : r_k + pBYTECNT_SIZE'(1);
                end
                S_RD_CAP: begin
                    r_rsp_data <= bus.read_data;
                end
                S_RD_HOLD: begin
                    if (w_rsp_hs) r_k <= w_last ? '0 : r_k + pBYTECNT_SIZE'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.reg_address   = r_address;
    assign bus.reg_bytecnt   = r_k;
    assign bus.write_data    = r_write_data;
    assign bus.reg_read      = r_reg_read;
    assign bus.reg_write     = r_reg_write;
    assign bus.reg_addrvalid = r_addrvalid;
    assign bus.busy          = r_busy;
endmodule
`default_nettype wire

// File: doc/reg_bus_initiator.md
# reg_bus_initiator

Byte-stream to register-bus initiator: decodes framed commands from a host byte stream into address/byte-count/strobe cycles on the shared register bus that every register block (main, front-end) decodes. Writes deliver one byte per strobe with an incrementing `reg_bytecnt`. Reads hold `reg_read` high for the whole burst and return each byte on a response stream with backpressure. It sits between the host transport and all register responders, in the `cwusb_clk` domain.

## Interface
- `pBYTECNT_SIZE`, default 7: width of `reg_bytecnt`; the burst length field is also 7 bits, so the maximum burst is 127 bytes.
- `cwusb_clk`  in  1  sole clock.
- `reset_n_i`  in  1  reset, synchronous and active-low.
- `cmd_data`  in  8  command stream byte.
- `cmd_valid`  in  1  `cmd_data` is valid.
- `cmd_ready`  out  1  initiator accepts `cmd_data` this cycle.
- `rsp_data`  out  8  read-back byte.
- `rsp_valid`  out  1  `rsp_data` is valid.
- `rsp_ready`  in  1  consumer accepts `rsp_data`.
- `reg_address`  out  8  register address.
- `reg_bytecnt`  out  pBYTECNT_SIZE  byte index within the burst.
- `write_data`  out  8  write byte.
- `read_data`  in  8  responder read byte (OR of all responders).
- `reg_read`  out  1  read flag.
- `reg_write`  out  1  write strobe.
- `reg_addrvalid`  out  1  address valid.
- `busy`  out  1  a command is in progress (state is not IDLE).

## Operation
- Frame format:
  - byte0 = address.
  - byte1 = {rw, len[6:0]}, where rw=1 means read.
  - For writes, `len` data bytes follow. Reads carry no further command bytes.
- A handshake occurs only on a cycle where `valid` and `ready` are both high. This applies to both streams.
- States and transitions:
  - IDLE: `cmd_ready`=1. On handshake, latch `reg_address` and go to HDR.
  - HDR: `cmd_ready`=1. On handshake, latch rw and len; clear the byte counter k.
    - len=0: go to DONE. This is a no-op: no strobe and no `reg_addrvalid`.
    - rw=0: go to WR_DATA.
    - rw=1: go to RD_SETUP.
  - WR_DATA: `cmd_ready`=1. On handshake, latch `write_data` and go to WR_STROBE.
  - WR_STROBE: `reg_write`=1 for exactly this cycle.
    - If k=len-1, go to DONE.
    - Otherwise increment k and go to WR_DATA.
  - RD_SETUP: `reg_read`=1. Go to RD_CAP.
  - RD_CAP: `reg_read`=1. Register `read_data` into `rsp_data` at the end of this cycle. Go to RD_HOLD.
  - RD_HOLD: `reg_read`=1, `rsp_valid`=1, `rsp_data` stable. On handshake:
    - If k=len-1, go to DONE.
    - Otherwise increment k and go to RD_SETUP.
  - DONE: `reg_addrvalid`, `reg_read` and `reg_write` all 0; `reg_bytecnt`=0. Go to IDLE.
- `reg_addrvalid`=1 in WR_DATA, WR_STROBE, RD_SETUP, RD_CAP and RD_HOLD; 0 otherwise.
- `reg_bytecnt`=k in all states; k is 0 outside a burst.
- `reg_read` must stay high continuously from the first RD_SETUP to the last RD_HOLD.
  - Responders detect the rising edge of `reg_read` to pop FIFOs.
  - A stalled `rsp_ready` must not create a low gap.
- `cmd_ready`=0 in all states other than IDLE, HDR and WR_DATA. Command bytes arriving during a read are held off, not dropped.
- `reg_address` and `write_data` hold their last latched value until relatched.
- `rsp_data` holds its value after the handshake.
- Reset values: all outputs 0, `cmd_ready`=0, `rsp_data`=0, state=IDLE.
  - `cmd_ready` goes to 1 on the first cycle after `reset_n_i` is released.
  - Reset asserted mid-burst aborts the burst within the same edge: all strobes and flags are 0 on the next cycle, and no partial response is emitted.

## Timing
- Write: a data byte handshaken on cycle N gives `reg_write`=1 on cycle N+1, with `write_data` and `reg_bytecnt` valid in that same cycle. Peak rate is 1 byte per 2 cycles.
- Read: `reg_bytecnt`=k is stable for RD_SETUP and RD_CAP. `read_data` is sampled at the end of the second of those cycles, which satisfies the "valid one cycle after `reg_read`" rule.
  - First `rsp_valid` appears 2 cycles after RD_SETUP entry, i.e. 3 cycles after the header handshake.
  - With `rsp_ready` held at 1, peak rate is 1 byte per 3 cycles.
- After the last byte, DONE gives at least 1 cycle of `reg_addrvalid`=0 between consecutive commands.
- k increments modulo 2^pBYTECNT_SIZE. Because len≤127, k never wraps.

## Test plan
- Write burst: address 0x21, header 0x03, data 0x11,0x22,0x33 with `cmd_valid` always 1 -> three 1-cycle `reg_write` pulses:
  - `reg_bytecnt` 0,1,2 with `write_data` 0x11,0x22,0x33.
  - `reg_addrvalid` high throughout, low for at least 1 cycle afterwards.
- Read burst with stalls: address 0x27, header 0x84, responder model returns 0xA0+bytecnt, `rsp_ready` low for 5 cycles on byte 1 -> `rsp_data` sequence 0xA0,0xA1,0xA2,0xA3.
  - Exactly one rising edge of `reg_read`, with no low gap during the stall.
- Zero length: address 0x05, header 0x00 -> no `reg_addrvalid`, `reg_read` or `reg_write` asserted; `busy` clears 2 cycles after the header.
- Back-to-back frames: a write frame immediately followed by a read frame -> `cmd_ready`=0 during the read; no bytes are lost; the read returns the correct data.
- Reset mid-read: `reset_n_i`=0 during RD_HOLD of byte 1 of 4 -> next cycle all outputs 0 and `rsp_valid`=0. After release, a fresh write frame executes correctly.
- Max length: read with len=127 -> 127 responses, `reg_bytecnt` reaching 126 with no wrap.
